// File: rtl/cordic_pkg.sv
// Shared fixed-point constants for the rotational and vectoring CORDIC cores.
// Angles are signed radians with FRAC_LENGTH fractional bits (1.0 = 4096).
//   wl_of()    : total operand width from integer and fractional bit counts
//   PI, HALF_PI: angle constants in the common fixed-point format
//   SCALING    : 1/K, where K is the CORDIC gain, in the same format
//   atan_lut() : round(atan(2^-i) * 4096). Constant function, no storage.
package cordic_pkg;

  localparam int PI      = 12868;
  localparam int HALF_PI = 6434;
  localparam int SCALING = 2487;

  function automatic int wl_of(input int int_len, input int frac_len);
    return int_len + frac_len;
  endfunction

  function automatic int atan_lut(input int i);
    case (i)
      0:       return 3217;
      1:       return 1899;
      2:       return 1003;
      3:       return 509;
      4:       return 256;
      5:       return 128;
      6:       return 64;
      7:       return 32;
      8:       return 16;
      9:       return 8;
      10:      return 4;
      11:      return 2;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/cordic_gain_sat.sv
// Combinational gain correction: multiplies by SCALING (1/K), drops
// FRAC_LENGTH fractional bits with an arithmetic shift and saturates
// the result to OUT_W signed bits.
//   din  : signed IN_W-bit value carrying CORDIC gain
//   dout : signed OUT_W-bit gain-corrected, clamped value
module cordic_gain_sat
  import cordic_pkg::*;
#(
  parameter int IN_W        = 20,
  parameter int OUT_W       = 18,
  parameter int FRAC_LENGTH = 12
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  // 14 bits holds SCALING as a positive signed value.
  localparam int PW = IN_W + 14;
  localparam logic signed [PW-1:0] SCALE_S = PW'(SCALING);
  localparam logic signed [PW-1:0] MAX_V = {{(PW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [PW-1:0] MIN_V = {{(PW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  function automatic logic signed [OUT_W-1:0] sat_wl(input logic signed [PW-1:0] v);
    if (v > MAX_V)      return MAX_V[OUT_W-1:0];
    else if (v < MIN_V) return MIN_V[OUT_W-1:0];
    else                return v[OUT_W-1:0];
  endfunction

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shifted;

  always_comb begin
    prod    = PW'(din) * SCALE_S;
    shifted = prod >>> FRAC_LENGTH;
    dout    = sat_wl(shifted);
  end

endmodule

// File: rtl/vectoring_cordic.sv
// Iterative vectoring-mode CORDIC. Rotates (Xo, Yo) until Y reaches zero,
// returning the gain-corrected magnitude in XN and Zo + atan2(Yo, Xo) in ZN.
//   CLK, RST  : clock (rising edge), synchronous active-high reset
//   ENABLE    : start pulse, samples Xo/Yo/Zo; restarts an operation in flight
//   Xo, Yo, Zo: signed vector and angle offset, Q(INT_LENGTH.FRAC_LENGTH)
//   XN, YN, ZN: magnitude, residual Y (~0), angle; held until next result
//   Done      : one-cycle result-valid pulse, NUM_OF_ITERATIONS+1 edges after load
//   Busy      : high while micro-rotations are in progress
module vectoring_cordic
  import cordic_pkg::*;
#(
  parameter int INT_LENGTH        = 6,
  parameter int FRAC_LENGTH       = 12,
  parameter int NUM_OF_ITERATIONS = 12
) (
  input  logic                                       CLK,
  input  logic                                       RST,
  input  logic                                       ENABLE,
  input  logic signed [INT_LENGTH+FRAC_LENGTH-1:0]  Xo,
  input  logic signed [INT_LENGTH+FRAC_LENGTH-1:0]  Yo,
  input  logic signed [INT_LENGTH+FRAC_LENGTH-1:0]  Zo,
  output logic signed [INT_LENGTH+FRAC_LENGTH-1:0]  XN,
  output logic signed [INT_LENGTH+FRAC_LENGTH-1:0]  YN,
  output logic signed [INT_LENGTH+FRAC_LENGTH-1:0]  ZN,
  output logic                                       Done,
  output logic                                       Busy
);

  localparam int WL = wl_of(INT_LENGTH, FRAC_LENGTH);
  localparam int XW = WL + 2;
  localparam int CW = $clog2(NUM_OF_ITERATIONS) + 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_OF_ITERATIONS);

  logic signed [XW-1:0] x_q, y_q;
  logic signed [WL-1:0] z_q, zo_q;
  logic [CW-1:0]        cnt_q;
  logic                 busy_q, done_q, zero_q;
  logic signed [WL-1:0] xn_q, yn_q, zn_q;

  logic signed [XW-1:0] xo_ext, yo_ext, x_sh, y_sh;
  logic signed [WL-1:0] atan_z;
  logic signed [WL-1:0] gx, gy;

  always_comb begin
    // Guard bits make -Xo exact even for the most negative input.
    xo_ext = XW'(Xo);
    yo_ext = XW'(Yo);
    x_sh   = x_q >>> cnt_q;
    y_sh   = y_q >>> cnt_q;
    atan_z = WL'(atan_lut(int'(cnt_q)));
  end

  cordic_gain_sat #(.IN_W(XW), .OUT_W(WL), .FRAC_LENGTH(FRAC_LENGTH)) u_gain_x (
    .din  (x_q),
    .dout (gx)
  );

  cordic_gain_sat #(.IN_W(XW), .OUT_W(WL), .FRAC_LENGTH(FRAC_LENGTH)) u_gain_y (
    .din  (y_q),
    .dout (gy)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      zo_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      zero_q <= 1'b0;
      xn_q   <= '0;
      yn_q   <= '0;
      zn_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (busy_q && cnt_q == LAST) begin
        // Finish: a zero vector has no defined angle, so pass Zo through.
        xn_q   <= zero_q ? '0 : gx;
        yn_q   <= zero_q ? '0 : gy;
        zn_q   <= zero_q ? zo_q : z_q;
        done_q <= 1'b1;
        busy_q <= 1'b0;
      end else if (busy_q) begin
        // Micro-rotation: turn toward y = 0, accumulating the angle used.
        if (y_q < 0) begin
          x_q <= x_q - y_sh;
          y_q <= y_q + x_sh;
          z_q <= z_q - atan_z;
        end else begin
          x_q <= x_q + y_sh;
          y_q <= y_q - x_sh;
          z_q <= z_q + atan_z;
        end
        cnt_q <= cnt_q + CW'(1);
      end

      // Load overrides any iteration in progress; a finish on the same edge
      // still publishes its result.
      if (ENABLE) begin
        // Left half-plane inputs are reflected through the origin and the
        // angle pre-rotated by +/-PI so iterations stay in convergence range.
        if (Xo < 0) begin
          x_q <= -xo_ext;
          y_q <= -yo_ext;
          z_q <= (Yo >= 0) ? Zo + WL'(PI) : Zo - WL'(PI);
        end else begin
          x_q <= xo_ext;
          y_q <= yo_ext;
          z_q <= Zo;
        end
        zo_q   <= Zo;
        zero_q <= (Xo == '0) && (Yo == '0);
        cnt_q  <= '0;
        busy_q <= 1'b1;
      end
    end
  end

  assign XN   = xn_q;
  assign YN   = yn_q;
  assign ZN   = zn_q;
  assign Done = done_q;
  assign Busy = busy_q;

endmodule

// File: tb/tb_vectoring_cordic.sv
module tb_vectoring_cordic;

  localparam int WL  = 18;
  localparam int LAT = 13;

  logic                 CLK = 1'b0;
  logic                 RST = 1'b1;
  logic                 ENABLE = 1'b0;
  logic signed [WL-1:0] Xo = '0, Yo = '0, Zo = '0;
  logic signed [WL-1:0] XN, YN, ZN;
  logic                 Done, Busy;

  int n_checks = 0;
  int n_fail   = 0;

  vectoring_cordic #(.INT_LENGTH(6), .FRAC_LENGTH(12), .NUM_OF_ITERATIONS(12)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .ENABLE (ENABLE),
    .Xo     (Xo),
    .Yo     (Yo),
    .Zo     (Zo),
    .XN     (XN),
    .YN     (YN),
    .ZN     (ZN),
    .Done   (Done),
    .Busy   (Busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    string name;
    int xo, yo, zo;
    int xn, xn_tol;
    int zn, zn_tol;
    int yn_tol;   // -1: residual Y not checked
  } vec_t;

  vec_t vecs[7];

  task automatic check_tol(input string nm, input int act, input int exp, input int tol);
    n_checks++;
    if (act - exp > tol || exp - act > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", nm, act, exp, tol);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_op(input int xo, input int yo, input int zo);
    Xo = WL'(xo);
    Yo = WL'(yo);
    Zo = WL'(zo);
    ENABLE = 1'b1;
  endtask

  // Waits for Done after a load edge; returns edges counted (or -1 on timeout).
  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (Done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic check_result(input vec_t v);
    check_tol({v.name, " XN"}, int'(XN), v.xn, v.xn_tol);
    check_tol({v.name, " ZN"}, int'(ZN), v.zn, v.zn_tol);
    if (v.yn_tol >= 0) check_tol({v.name, " YN"}, int'(YN), 0, v.yn_tol);
  endtask

  initial begin
    int lat, ndone, first;

    vecs[0] = '{"diag",     4096,    4096,    0,    5793,   8, 3217,   8, 8};
    vecs[1] = '{"neg_x",    -4096,   0,       0,    4096,   8, 12868,  8, 8};
    vecs[2] = '{"neg_y",    0,       -8192,   0,    8192,   8, -6434,  8, 8};
    vecs[3] = '{"zero",     0,       0,       100,  0,      0, 100,    0, 0};
    vecs[4] = '{"zoffs",    4096,    0,       1000, 4096,   8, 1000,   8, 8};
    vecs[5] = '{"sat_pos",  131071,  131071,  0,    131071, 0, 3217,   8, -1};
    vecs[6] = '{"sat_neg",  -131072, -131072, 0,    131071, 0, -9651,  8, -1};

    // Reset state
    tick(); tick();
    RST = 1'b0;
    check_tol("reset XN", int'(XN), 0, 0);
    check_tol("reset YN", int'(YN), 0, 0);
    check_tol("reset ZN", int'(ZN), 0, 0);
    check_tol("reset Done", int'(Done), 0, 0);
    check_tol("reset Busy", int'(Busy), 0, 0);

    // Reset wins over ENABLE
    RST = 1'b1;
    drive_op(4096, 4096, 0);
    tick();
    RST = 1'b0;
    ENABLE = 1'b0;
    check_tol("reset_vs_enable Busy", int'(Busy), 0, 0);

    // Table-driven single operations
    foreach (vecs[i]) begin
      tick();
      drive_op(vecs[i].xo, vecs[i].yo, vecs[i].zo);
      tick();
      ENABLE = 1'b0;
      check_tol({vecs[i].name, " Busy"}, int'(Busy), 1, 0);
      wait_done(lat);
      check_tol({vecs[i].name, " latency"}, lat, LAT, 0);
      check_result(vecs[i]);
      check_tol({vecs[i].name, " Busy_at_done"}, int'(Busy), 0, 0);
      tick();
      check_tol({vecs[i].name, " Done_width"}, int'(Done), 0, 0);
      check_result(vecs[i]);   // outputs hold while idle
    end

    // Abort: restart at iteration 5 with (0, 4096)
    tick();
    drive_op(4096, 4096, 0);
    tick();
    ENABLE = 1'b0;
    for (int n = 0; n < 5; n++) tick();
    drive_op(0, 4096, 0);
    tick();
    ENABLE = 1'b0;
    ndone = 0;
    first = -1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (Done) begin
        ndone++;
        if (first < 0) begin
          first = n;
          check_tol("abort XN", int'(XN), 4096, 8);
          check_tol("abort ZN", int'(ZN), 6434, 8);
        end
      end
    end
    check_tol("abort done_count", ndone, 1, 0);
    check_tol("abort latency", first, LAT, 0);

    // Reset mid-iteration: outputs were nonzero, now cleared, no Done
    drive_op(-4096, 0, 0);
    tick();
    ENABLE = 1'b0;
    for (int n = 0; n < 4; n++) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check_tol("midreset XN", int'(XN), 0, 0);
    check_tol("midreset ZN", int'(ZN), 0, 0);
    check_tol("midreset Busy", int'(Busy), 0, 0);
    ndone = 0;
    for (int n = 0; n < 20; n++) begin
      if (Done) ndone++;
      tick();
    end
    check_tol("midreset done_count", ndone, 0, 0);

    // Back-to-back: second load on the same edge that finishes the first
    drive_op(vecs[0].xo, vecs[0].yo, vecs[0].zo);
    tick();
    ENABLE = 1'b0;
    for (int n = 0; n < LAT - 1; n++) tick();
    drive_op(vecs[1].xo, vecs[1].yo, vecs[1].zo);
    tick();
    ENABLE = 1'b0;
    check_tol("b2b first Done", int'(Done), 1, 0);
    check_result(vecs[0]);
    check_tol("b2b Busy", int'(Busy), 1, 0);
    wait_done(lat);
    check_tol("b2b spacing", lat, LAT, 0);
    check_result(vecs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
